pooling_window_ctrl: RTL and testbench

- Parametrised successor to the fixed 2x2 pooling sequencer. On each window-ready pulse it issues WIN sequential read/write address pairs and a per-element select to the pooling datapath and buffer.
- Adds:
  - configurable window size, buffer depth and warm-up count;
  - queueing of window requests that arrive while busy, with overflow flag;
  - a window-done pulse and a synchronous clear.
- Sits between the layer-2 output valid and the pooling buffer/comparator.

---
 rtl/pooling_window_ctrl_if.sv | 31 +++
 rtl/pooling_window_ctrl.sv | 132 +++++++++++++
 tb/tb_pooling_window_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pooling_window_ctrl_if.sv
// Pooling window control bus.
// Groups the request side (clear, valid_in) and the buffer/datapath side
// (addresses, write enable, element select, status flags) of
// pooling_window_ctrl.
//   master : drives clear / valid_in, observes everything else
//   slave  : the controller; drives addresses, we, ctrl_sel and status
interface pooling_window_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int SEL_W  = 2
);
  logic              clear;
  logic              valid_in;
  logic              init_phase;
  logic              we;
  logic [ADDR_W-1:0] read_addr;
  logic [ADDR_W-1:0] write_addr;
  logic [SEL_W-1:0]  ctrl_sel;
  logic              busy;
  logic              win_done;
  logic              overflow;

  modport master (
    output clear, valid_in,
    input  init_phase, we, read_addr, write_addr, ctrl_sel, busy, win_done, overflow
  );

  modport slave (
    input  clear, valid_in,
    output init_phase, we, read_addr, write_addr, ctrl_sel, busy, win_done, overflow
  );
endinterface

// File: rtl/pooling_window_ctrl.sv
// Pooling window sequencer.
// On each window request it issues WIN sequential read/write address pairs
// plus an element select to the pooling buffer/comparator. Requests that
// arrive while a window is in flight are counted in a saturating pending
// counter; a dropped request sets the sticky overflow flag.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : pooling_window_ctrl_if.slave
//            clear (sync soft reset, wins over valid_in), valid_in (request
//            pulse), init_phase, we, read_addr, write_addr, ctrl_sel, busy,
//            win_done (one-cycle pulse), overflow (sticky)
// Optional build macro:
//   POOL_BACK_TO_BACK_EN : chain the next window straight out of the last
//   RUN step when a request is waiting, giving a window spacing of WIN.
module pooling_window_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int WIN        = 4,
  parameter int SEL_W      = 2,
  parameter int BUF_DEPTH  = 192,
  parameter int INIT_COUNT = 49,
  parameter int PEND_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pooling_window_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int                WC_W      = $clog2(INIT_COUNT + 1);
  localparam logic [SEL_W-1:0]  LAST_STEP = SEL_W'(WIN - 1);
  localparam logic [ADDR_W-1:0] WRAP_ADDR = ADDR_W'(BUF_DEPTH);
  localparam logic [WC_W-1:0]   INIT_CNT  = WC_W'(INIT_COUNT);

  state_t            state;
  logic [SEL_W-1:0]  step;
  logic [PEND_W-1:0] pending;
  logic [WC_W-1:0]   win_count;
  logic              init_phase, we, busy, win_done, overflow;
  logic [ADDR_W-1:0] read_addr, write_addr;
  logic [SEL_W-1:0]  ctrl_sel;

  logic              pend_nz, pend_full, start_req, warm;
  logic [PEND_W-1:0] pend_start, pend_queue;
  logic [WC_W-1:0]   wc_start;
  logic [ADDR_W-1:0] ra_inc;

  assign pend_nz   = |pending;
  assign pend_full = &pending;
  assign start_req = bus.valid_in | pend_nz;
  assign warm      = win_count >= INIT_CNT;
  // A start consumes one queued request; a coincident valid_in replaces it.
  assign pend_start = (pend_nz && !bus.valid_in) ? pending - PEND_W'(1) : pending;
  // Request while busy: queue it unless the counter is already full.
  assign pend_queue = (bus.valid_in && !pend_full) ? pending + PEND_W'(1) : pending;
  assign wc_start   = warm ? win_count : win_count + WC_W'(1);
  assign ra_inc     = read_addr + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE; step <= '0; pending <= '0; win_count <= '0;
      init_phase <= 1'b1; we <= 1'b0; busy <= 1'b0; win_done <= 1'b0; overflow <= 1'b0;
      read_addr <= '0; write_addr <= '0; ctrl_sel <= '0;
    end else if (bus.clear) begin
      state <= IDLE; step <= '0; pending <= '0; win_count <= '0;
      init_phase <= 1'b1; we <= 1'b0; busy <= 1'b0; win_done <= 1'b0; overflow <= 1'b0;
      read_addr <= '0; write_addr <= '0; ctrl_sel <= '0;
    end else begin
      win_done <= 1'b0;
      case (state)
        IDLE: begin
          we <= 1'b0;
          if (start_req) begin
            state     <= RUN;
            busy      <= 1'b1;
            step      <= '0;
            pending   <= pend_start;
            win_count <= wc_start;
            if (warm) init_phase <= 1'b0;
          end
        end
        RUN: begin
          we         <= 1'b1;
          ctrl_sel   <= step;
          write_addr <= read_addr - ADDR_W'(1);
          read_addr  <= ra_inc;
          pending    <= pend_queue;
          overflow   <= overflow | (bus.valid_in & pend_full);
          if (step == LAST_STEP) begin
`ifdef POOL_BACK_TO_BACK_EN
            if (start_req) begin
              // Chain: this cycle doubles as DONE and the next start.
              step      <= '0;
              win_done  <= 1'b1;
              pending   <= pend_start;
              overflow  <= overflow;
              win_count <= wc_start;
              if (warm) init_phase <= 1'b0;
              if (ra_inc == WRAP_ADDR) read_addr <= '0;
            end else begin
              state <= DONE;
            end
`else
            state <= DONE;
`endif
          end else begin
            step <= step + SEL_W'(1);
          end
        end
        DONE: begin
          we       <= 1'b0;
          win_done <= 1'b1;
          busy     <= 1'b0;
          pending  <= pend_queue;
          overflow <= overflow | (bus.valid_in & pend_full);
          if (read_addr == WRAP_ADDR) read_addr <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.init_phase = init_phase;
  assign bus.we         = we;
  assign bus.read_addr  = read_addr;
  assign bus.write_addr = write_addr;
  assign bus.ctrl_sel   = ctrl_sel;
  assign bus.busy       = busy;
  assign bus.win_done   = win_done;
  assign bus.overflow   = overflow;
endmodule

// File: tb/tb_pooling_window_ctrl.sv
// Bench for pooling_window_ctrl: directed scenarios followed by random
// request/clear traffic. Expected outputs come from a window-timeline model
// (window start times, window index arithmetic for addresses, a request
// count for queueing).
module tb_pooling_window_ctrl;
  localparam int ADDR_W = 32, WIN = 4, SEL_W = 2, BUF_DEPTH = 192, INIT_COUNT = 49, PEND_W = 3;
`ifdef POOL_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pooling_window_ctrl_if #(.ADDR_W(ADDR_W), .SEL_W(SEL_W)) bus ();

  pooling_window_ctrl #(
    .ADDR_W(ADDR_W), .WIN(WIN), .SEL_W(SEL_W), .BUF_DEPTH(BUF_DEPTH),
    .INIT_COUNT(INIT_COUNT), .PEND_W(PEND_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int wd_cnt = 0;

  // Timeline model state
  int t, n_started, last_s, pend;
  bit m_ovf, m_init, e_we, e_busy, e_wd;
  logic [ADDR_W-1:0] e_ra, e_wa;
  logic [SEL_W-1:0]  e_sel;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("init_phase", 64'(bus.init_phase), 64'(m_init));
    chk("we",         64'(bus.we),         64'(e_we));
    chk("read_addr",  64'(bus.read_addr),  64'(e_ra));
    chk("write_addr", 64'(bus.write_addr), 64'(e_wa));
    chk("ctrl_sel",   64'(bus.ctrl_sel),   64'(e_sel));
    chk("busy",       64'(bus.busy),       64'(e_busy));
    chk("win_done",   64'(bus.win_done),   64'(e_wd));
    chk("overflow",   64'(bus.overflow),   64'(m_ovf));
  endtask

  task automatic m_reset();
    t = 0; n_started = 0; last_s = 0; pend = 0;
    m_ovf = 0; m_init = 1; e_we = 0; e_busy = 0; e_wd = 0;
    e_ra = '0; e_wa = '0; e_sel = '0;
  endtask

  // Advance the model by one clock edge with the sampled inputs.
  task automatic m_edge(input bit v, input bit clr);
    bit idle_now, b2b_slot, start, chained;
    int d, base, prev_base;
    if (clr) begin
      m_reset();
      return;
    end
    t++;
    idle_now  = (n_started == 0) || (t - last_s >= WIN + 2);
    b2b_slot  = B2B && (n_started > 0) && (t - last_s == WIN);
    start     = (idle_now || b2b_slot) && (v || pend > 0);
    chained   = start && b2b_slot;
    prev_base = ((n_started - 1) * WIN) % BUF_DEPTH;
    if (start) begin
      if (pend > 0 && !v) pend--;
      if (n_started >= INIT_COUNT) m_init = 0;
      last_s = t;
      n_started++;
    end else if (v) begin
      if (pend == (1 << PEND_W) - 1) m_ovf = 1;
      else pend++;
    end
    d    = t - last_s;
    base = ((n_started - 1) * WIN) % BUF_DEPTH;
    e_wd = 0;
    if (n_started == 0) begin
      e_we = 0; e_busy = 0;
    end else if (start) begin
      e_busy = 1; e_ra = ADDR_W'(base); e_we = chained;
      if (chained) begin
        e_sel = SEL_W'(WIN - 1); e_wa = ADDR_W'(prev_base + WIN - 2); e_wd = 1;
      end
    end else if (d >= 1 && d <= WIN) begin
      e_we = 1; e_busy = 1; e_sel = SEL_W'(d - 1);
      e_wa = ADDR_W'(base + d - 2); e_ra = ADDR_W'(base + d);
    end else if (d == WIN + 1) begin
      e_we = 0; e_busy = 0; e_wd = 1; e_ra = ADDR_W'((n_started * WIN) % BUF_DEPTH);
    end else begin
      e_we = 0; e_busy = 0;
    end
  endtask

  task automatic step(input bit v, input bit clr);
    bus.valid_in = v;
    bus.clear    = clr;
    @(posedge clk);
    m_edge(v, clr);
    #1;
    check_outputs();
    if (bus.win_done === 1'b1) wd_cnt++;
    bus.valid_in = 1'b0;
    bus.clear    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.clear    = 1'b0;
    m_reset();
    #12;
    check_outputs();
    rst_n = 1'b1;

    // Single window from reset
    step(1, 0);
    repeat (7) step(0, 0);

    // 48 spaced windows: read address wraps after the 48th DONE
    do_reset();
    for (int i = 0; i < 48; i++) begin
      step(1, 0);
      repeat (WIN + 1) step(0, 0);
    end
    chk("wrap_read_addr", 64'(bus.read_addr), 64'd0);
    step(1, 0);
    step(0, 0);
    chk("wrap_first_write_addr", 64'(bus.write_addr), 64'hFFFF_FFFF);
    repeat (WIN) step(0, 0);
    chk("init_after_49", 64'(bus.init_phase), 64'd1);
    step(1, 0);
    chk("init_after_50", 64'(bus.init_phase), 64'd0);
    repeat (WIN + 1) step(0, 0);

    // Two requests during RUN are queued and served
    do_reset();
    wd_cnt = 0;
    step(1, 0);
    step(1, 0);
    step(1, 0);
    repeat (16) step(0, 0);
    chk("queued_win_done_count", 64'(wd_cnt), 64'd3);
    chk("queued_no_overflow", 64'(bus.overflow), 64'd0);

    // Request burst saturates the pending counter
    do_reset();
    step(1, 0);
    repeat (12) step(1, 0);
    repeat (70) step(0, 0);
    chk("overflow_sticky", 64'(bus.overflow), 64'd1);
    chk("drained_idle", 64'(bus.busy), 64'd0);

    // Async reset mid-window with a coincident request
    do_reset();
    step(1, 0);
    step(0, 0);
    step(0, 0);
    bus.valid_in = 1'b1;
    rst_n = 1'b0;
    #1;
    m_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    bus.valid_in = 1'b0;
    rst_n = 1'b1;

    // Synchronous clear mid-window beats valid_in
    step(1, 0);
    step(0, 0);
    step(0, 0);
    step(1, 1);
    repeat (3) step(0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 63) == 0);
    repeat (60) step(0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
